hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Multi-cycle multiply/divide engine that owns the architectural HI and LO registers. It receives MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage and iterates one bit per cycle. It holds the results in HI/LO for MFHI/MFLO reads, which are returned to the execute stage as its HI/LO inputs. A stall output holds the pipeline while a result is pending.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width; the iteration count equals DATA_WIDTH; only 32 is verified.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
op_valid  input  1  op/A/B valid this cycle
op  input  5  control code, same encoding as the ALU control field: MULT=10000, MULTU=10001, DIV=10010, DIVU=10011, MTLO=10101, MTHI=10110, MFLO=11000, MFHI=11001
A  input  32  rs operand (dividend/multiplicand; MTHI/MTLO source)
B  input  32  rt operand (divisor/multiplier)
busy  output  1  high while state is not IDLE
stall  output  1  busy && op_valid && op is one of the eight codes above; combinational
done  output  1  one-cycle pulse after HI/LO are written by a mult/div
hi_out  output  32  HI register, registered
lo_out  output  32  LO register, registered

Behaviour:
- Reset (asynchronous): HI=0, LO=0, state=IDLE, counter=0, done=0, busy=0. Reset mid-operation aborts the operation; the partial result is discarded.
- States: IDLE, CALC, FIXUP.
- IDLE, op_valid, op in MULT/MULTU/DIV/DIVU:
  - At edge E0, latch operand magnitudes (signed ops use |x|; unsigned ops use x).
  - Latch neg_q = A[31]^B[31] and neg_r = A[31] for signed ops (0 for unsigned).
  - Latch div0 = (B==0) and the kind (mul/div). counter=0, state to CALC.
- IDLE, op_valid, MTHI/MTLO: at the next edge HI (or LO) = A; the other register is unchanged; state stays IDLE; done stays 0.
- IDLE, other codes (including MFHI/MFLO): no state change. Reads use hi_out/lo_out directly.
- CALC: one iteration per edge, E1..E32, with counter 0..31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - At counter==31, state to FIXUP.
- FIXUP, edge E33:
  - Multiply: {HI,LO} = neg_q ? -product : product, with 64-bit two's-complement negation.
  - Divide: LO = neg_q ? -quot : quot; HI = neg_r ? -rem : rem.
  - div0 overrides the divide result: LO=32'hFFFFFFFF, HI=A as latched (raw, no fixup).
  - State to IDLE; done=1 for the cycle after E33.
- Latency: hi_out/lo_out carry the new result 33 edges after acceptance. busy=1 during the 33 cycles between E0 and E33.
- While busy, all requests are ignored (not queued). The requester holds op/A/B while stall=1 and is accepted once the unit returns to IDLE.
- During the done cycle the unit is IDLE, so a back-to-back op is accepted in that same cycle.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (magnitude 2^31 fits in 32 bits unsigned; its negation wraps to itself).
- MULT 0x80000000 * 0x80000000: HI=0x40000000, LO=0.
- Operand changes after E0 have no effect on the running operation.

Decomposition:
- Shared package mips_alu_pkg: control_t (all 5-bit control codes, moved out of the ALU so both blocks import it) and DATA_WIDTH.
- Local typedef for the state enum {IDLE, CALC, FIXUP}.
- One sub-module, muldiv_step: combinational single-iteration datapath (add-shift / subtract-shift, select by kind), instantiated once.
- FSM, counter, sign fixup and HI/LO registers live in hilo_muldiv_unit.

Test Plan:
1. MULTU A=FFFFFFFF B=FFFFFFFF:
   - busy for 33 cycles, then done pulse.
   - HI=FFFFFFFE, LO=00000001.
2. MULT A=FFFFFFFD(-3) B=00000007 -> HI=FFFFFFFF, LO=FFFFFFEB (-21). DIV A=FFFFFFF9(-7) B=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF.
3. DIVU A=00000064 B=00000007 -> LO=0000000E, HI=00000002. DIV A=12345678 B=0 -> LO=FFFFFFFF, HI=12345678.
4. MTHI A=DEADBEEF issued at cycle 5 of a MULTU:
   - stall=1 until done; HI/LO unchanged meanwhile.
   - Accepted in the done cycle; next edge HI=DEADBEEF, LO=multiply LO.
5. MTLO A=CAFEF00D in IDLE -> LO=CAFEF00D next edge, HI unchanged, done=0. MFLO in IDLE -> stall=0, lo_out=CAFEF00D.
6. Assert reset asynchronously mid-edge at CALC counter=10:
   - busy, done, HI and LO go to 0 immediately.
   - After release, DIVU 9/3 gives LO=3, HI=0 at 33 cycles.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared definitions for the ALU and the HI/LO multiply/divide unit.
// Holds the 5-bit control-field encoding and the datapath width so both
// blocks decode the same op codes from a single place.
package mips_alu_pkg;

    // Operand, HI and LO width; the iterative engine runs one step per bit.
    localparam int DATA_WIDTH = 32;

    // Control-field codes that concern the HI/LO unit.
    typedef enum logic [4:0] {
        CTRL_MULT  = 5'b10000,
        CTRL_MULTU = 5'b10001,
        CTRL_DIV   = 5'b10010,
        CTRL_DIVU  = 5'b10011,
        CTRL_MTLO  = 5'b10101,
        CTRL_MTHI  = 5'b10110,
        CTRL_MFLO  = 5'b11000,
        CTRL_MFHI  = 5'b11001
    } control_t;

    // True for the four codes that launch a multi-cycle mult/div.
    function automatic logic isMulDivStart(input logic [4:0] code);
        return (code == CTRL_MULT) || (code == CTRL_MULTU) ||
               (code == CTRL_DIV)  || (code == CTRL_DIVU);
    endfunction

    // True for the two signed launch codes.
    function automatic logic isSignedOp(input logic [4:0] code);
        return (code == CTRL_MULT) || (code == CTRL_DIV);
    endfunction

    // True for the two divide launch codes.
    function automatic logic isDivideOp(input logic [4:0] code);
        return (code == CTRL_DIV) || (code == CTRL_DIVU);
    endfunction

    // True for every code that touches HI/LO; these must wait while busy.
    function automatic logic isHiLoCode(input logic [4:0] code);
        return isMulDivStart(code) ||
               (code == CTRL_MTLO) || (code == CTRL_MTHI) ||
               (code == CTRL_MFLO) || (code == CTRL_MFHI);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath.
// The 2W-bit accumulator is interpreted per kind:
//   multiply: {partial product high, multiplier bits still to consume}
//   divide  : {partial remainder, dividend bits / quotient bits}
module muldiv_step #(
    parameter int DATA_WIDTH = mips_alu_pkg::DATA_WIDTH
) (
    input  logic                      isDiv,
    input  logic [2*DATA_WIDTH-1:0]   accIn,
    input  logic [DATA_WIDTH-1:0]     operand,
    output logic [2*DATA_WIDTH-1:0]   accOut
);

    localparam int W = DATA_WIDTH;

    logic [W:0] mulSum;
    logic [W:0] mulUpper;
    logic [W:0] divShifted;
    logic [W:0] divDiff;
    logic       divFits;

    // Multiply adds the multiplicand when the current multiplier bit is set,
    // then shifts right keeping the carry; divide shifts left one bit and
    // keeps the trial subtraction only when it does not go negative.
    always_comb begin
        mulSum     = {1'b0, accIn[2*W-1:W]} + {1'b0, operand};
        mulUpper   = accIn[0] ? mulSum : {1'b0, accIn[2*W-1:W]};
        divShifted = accIn[2*W-1:W-1];
        divFits    = (divShifted >= {1'b0, operand});
        divDiff    = divShifted - {1'b0, operand};
        if (isDiv) begin
            accOut = {(divFits ? divDiff[W-1:0] : divShifted[W-1:0]),
                      accIn[W-2:0], divFits};
        end else begin
            accOut = {mulUpper, accIn[W-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide engine owning the architectural HI/LO pair.
// Operands are reduced to magnitudes at acceptance, iterated one bit per
// cycle by muldiv_step, and sign-corrected in a final FIXUP cycle.
module hilo_muldiv_unit #(
    parameter int DATA_WIDTH = mips_alu_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  busy,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;

    logic            isDiv_q;
    logic            negQuot_q;
    logic            negRem_q;
    logic            divZero_q;
    logic [W-1:0]    operand_q;
    logic [W-1:0]    rawA_q;
    logic [2*W-1:0]  acc_q;
    logic [2*W-1:0]  accStep;

    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic            done_q;

    logic            startReq;
    logic            reqSigned;
    logic            reqDiv;
    logic [W-1:0]    magA;
    logic [W-1:0]    magB;

    logic [2*W-1:0]  mulResult;
    logic [W-1:0]    quotResult;
    logic [W-1:0]    remResult;

    muldiv_step #(
        .DATA_WIDTH (W)
    ) u_step (
        .isDiv   (isDiv_q),
        .accIn   (acc_q),
        .operand (operand_q),
        .accOut  (accStep)
    );

    // Decode the incoming request and form operand magnitudes.
    always_comb begin
        startReq  = op_valid && (state_q == IDLE) && mips_alu_pkg::isMulDivStart(op);
        reqSigned = mips_alu_pkg::isSignedOp(op);
        reqDiv    = mips_alu_pkg::isDivideOp(op);
        magA      = (reqSigned && A[W-1]) ? (~A + 1'b1) : A;
        magB      = (reqSigned && B[W-1]) ? (~B + 1'b1) : B;
    end

    // State register with asynchronous abort on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state: launch, iterate W times, then one fixup cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (startReq) begin
                    state_d = CALC;
                    count_d = '0;
                end
            end
            CALC: begin
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    state_d = FIXUP;
                    count_d = '0;
                end
            end
            FIXUP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Status outputs: busy tracks state, stall holds HI/LO users off.
    always_comb begin
        busy   = (state_q != IDLE);
        stall  = busy && op_valid && mips_alu_pkg::isHiLoCode(op);
        done   = done_q;
        hi_out = hi_q;
        lo_out = lo_q;
    end

    // Latch operation attributes at launch and advance the accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isDiv_q   <= 1'b0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            operand_q <= '0;
            rawA_q    <= '0;
            acc_q     <= '0;
        end else if (startReq) begin
            isDiv_q   <= reqDiv;
            negQuot_q <= reqSigned && (A[W-1] ^ B[W-1]);
            negRem_q  <= reqSigned && A[W-1];
            divZero_q <= (B == '0);
            rawA_q    <= A;
            operand_q <= reqDiv ? magB : magA;
            acc_q     <= reqDiv ? {{W{1'b0}}, magA} : {{W{1'b0}}, magB};
        end else if (state_q == CALC) begin
            acc_q     <= accStep;
        end
    end

    // Sign correction of the magnitude result.
    always_comb begin
        mulResult  = negQuot_q ? (~acc_q + 1'b1) : acc_q;
        quotResult = negQuot_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
        remResult  = negRem_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
    end

    // HI/LO update: fixup writes the mult/div result, MTHI/MTLO write in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == FIXUP);
            if (state_q == FIXUP) begin
                if (!isDiv_q) begin
                    hi_q <= mulResult[2*W-1:W];
                    lo_q <= mulResult[W-1:0];
                end else if (divZero_q) begin
                    hi_q <= rawA_q;
                    lo_q <= '1;
                end else begin
                    hi_q <= remResult;
                    lo_q <= quotResult;
                end
            end else if ((state_q == IDLE) && op_valid) begin
                if (op == mips_alu_pkg::CTRL_MTHI) begin
                    hi_q <= A;
                end else if (op == mips_alu_pkg::CTRL_MTLO) begin
                    lo_q <= A;
                end
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: launches push the hand-computed
// HI/LO pair, and a monitor compares on every done pulse.
module tb_hilo_muldiv_unit;

    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MTLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;
    localparam logic [4:0] OP_MFLO  = 5'b11000;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [4:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sbQ[$];
    exp_t monExp;
    int   checks = 0;
    int   errors = 0;

    hilo_muldiv_unit #(
        .DATA_WIDTH (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=1 required=0");
            end else begin
                monExp = sbQ.pop_front();
                checkOutput({monExp.name, "_hi"}, hi_out, monExp.hi);
                checkOutput({monExp.name, "_lo"}, lo_out, monExp.lo);
            end
        end
    end

    // Present one request for a single edge, then scramble the operands.
    task automatic applyStimulus(input logic [4:0] code, input logic [31:0] a,
                                 input logic [31:0] b);
        op_valid = 1'b1;
        op       = code;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        A        = 32'h5A5A5A5A;
        B        = 32'hA5A5A5A5;
    endtask

    task automatic launch(input logic [4:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expHi,
                          input logic [31:0] expLo, input string name);
        exp_t e;
        e.hi   = expHi;
        e.lo   = expLo;
        e.name = name;
        sbQ.push_back(e);
        applyStimulus(code, a, b);
    endtask

    // Bounded wait for done, counting busy cycles on the way.
    task automatic waitDone(input string name);
        int busyCycles = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) busyCycles++;
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({name, "_busy_cycles"}, 32'(busyCycles), 32'd33);
    endtask

    initial begin
        bit seen;
        reset    = 1'b1;
        op_valid = 1'b0;
        op       = 5'b00000;
        A        = '0;
        B        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_hi", hi_out, 32'h0);
        checkOutput("reset_lo", lo_out, 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);

        // Unsigned full-scale multiply and single-cycle done pulse.
        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        waitDone("multu_max");
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(done), 32'd0);

        // Signed multiply and divide, issued back-to-back in the done cycle.
        launch(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");
        waitDone("mult_neg");
        launch(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        waitDone("div_neg");
        launch(OP_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "divu_100_7");
        waitDone("divu_100_7");
        launch(OP_DIV, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, "div_zero");
        waitDone("div_zero");
        launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_minint");
        waitDone("div_minint");
        launch(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minint");
        waitDone("mult_minint");

        // MTHI presented while busy: stalled, HI/LO frozen, accepted in done cycle.
        launch(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, "multu_x2");
        repeat (4) @(posedge clk);
        #1;
        op_valid = 1'b1;
        op       = OP_MTHI;
        A        = 32'hDEADBEEF;
        B        = 32'h0;
        seen     = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                checkOutput("mthi_stall", 32'(stall), 32'd1);
                checkOutput("mthi_hold_hi", hi_out, 32'h40000000);
                checkOutput("mthi_hold_lo", lo_out, 32'h00000000);
            end
        end
        checkOutput("mthi_done_seen", 32'(seen), 32'd1);
        checkOutput("mthi_stall_in_done", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        checkOutput("mthi_hi", hi_out, 32'hDEADBEEF);
        checkOutput("mthi_lo", lo_out, 32'hFFFFFFFE);

        // MTLO and MFLO while idle.
        applyStimulus(OP_MTLO, 32'hCAFEF00D, 32'h0);
        @(negedge clk);
        checkOutput("mtlo_lo", lo_out, 32'hCAFEF00D);
        checkOutput("mtlo_hi", hi_out, 32'hDEADBEEF);
        checkOutput("mtlo_done", 32'(done), 32'd0);
        op_valid = 1'b1;
        op       = OP_MFLO;
        #1;
        checkOutput("mflo_stall", 32'(stall), 32'd0);
        checkOutput("mflo_lo", lo_out, 32'hCAFEF00D);
        op_valid = 1'b0;

        // Asynchronous reset during CALC at counter 10 aborts the operation.
        @(negedge clk);
        applyStimulus(OP_MULTU, 32'h00000005, 32'h00000007);
        repeat (10) @(posedge clk);
        #3;
        checkOutput("pre_abort_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_hi", hi_out, 32'h0);
        checkOutput("abort_lo", lo_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        launch(OP_DIVU, 32'h00000009, 32'h00000003, 32'h00000000, 32'h00000003, "divu_9_3");
        waitDone("divu_9_3");

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
